enum_sequence_checker: RTL and testbench
========================================

// Module: enum_sequence_checker
//
// PURPOSE
//   Receive-side monitor for an enumerated-code stream driven one code per clock.
//   Samples a DW-bit code on each valid cycle.
//   Checks that the codes step strictly through 0,1,...,LAST, e.g. A0..A4 or H..N.
//   Reports progress, completion, first mismatch and the number of completed passes.
//   Sits beside the stimulus generator in waveform example benches as its checking end.
//
// PARAMETERS
//   DW       3   code width in bits
//   LAST     4   final code of the sequence; LAST < 2**DW, checked by $error at elaboration
//   HOLD_OK  0   1: a repeat of the last accepted code on a valid cycle is tolerated
//   WRAP     1   1: code 0 after DONE starts a new pass; 0: any valid after DONE is an error
//   PW       8   width of the pass counter
//
// PORTS
//   clk       in   1              clock, rising edge
//   rst_n     in   1              asynchronous active-low reset
//   clr       in   1              synchronous clear; returns the block to IDLE
//   vld       in   1              code on dat is valid this cycle
//   dat       in   DW             enumerated code
//   state     out  2              IDLE=0, RUN=1, DONE=2, FAIL=3
//   exp       out  DW             next expected code
//   cnt       out  $clog2(LAST+2) codes accepted in the current pass
//   done      out  1              high while state==DONE
//   err       out  1              high while state==FAIL (sticky)
//   err_exp   out  DW             expected code at the first error
//   err_dat   out  DW             received code at the first error
//   pass_cnt  out  PW             completed passes, saturating
//
// BEHAVIOUR
//   Reset (rst_n=0, asynchronous)
//     - state=IDLE, exp=0, cnt=0, err_exp=0, err_dat=0, pass_cnt=0.
//     - Asserting reset mid-pass discards the pass immediately.
//   Registered outputs
//     - All outputs are registered.
//     - A code sampled at edge k is reflected in the outputs after edge k; latency is 1 cycle.
//   Idle cycles
//     - vld=0 cycles change nothing in any state; gaps between codes are legal.
//   Clear priority
//     - clr=1 beats vld. The sample is discarded and all state returns to reset values.
//     - pass_cnt is also cleared.
//   IDLE
//     - vld & dat==0: RUN, exp<=1, cnt<=1.
//     - vld & dat!=0: FAIL, err_exp<=0, err_dat<=dat.
//   RUN
//     - vld & dat==exp & exp<LAST: exp<=exp+1, cnt<=cnt+1.
//     - vld & dat==exp & exp==LAST: DONE, cnt<=LAST+1, exp<=0, pass_cnt<=pass_cnt+1.
//       pass_cnt saturates at 2**PW-1 and does not wrap.
//     - vld & HOLD_OK & dat==exp-1: no change (hold).
//     - any other vld: FAIL, err_exp<=exp, err_dat<=dat.
//   DONE
//     - vld & WRAP & dat==0: RUN, exp<=1, cnt<=1.
//     - any other vld: FAIL, err_exp<=0, err_dat<=dat.
//     - HOLD_OK also tolerates dat==LAST while in DONE.
//   FAIL
//     - Absorbing; only clr or rst_n leave it.
//     - err_exp and err_dat hold the first error; later codes are ignored.
//   Width rules
//     - exp increments only while exp<LAST, so it never wraps inside DW.
//     - cnt is wide enough to hold LAST+1.
//   Edge case: LAST=0
//     - A single dat==0 completes a pass; the next state is DONE directly from IDLE.
//     - pass_cnt is incremented.
//
// TESTING
//   1. Reset, then vld codes 0,1,2,3,4 on consecutive cycles.
//      -> cnt=5, done=1, pass_cnt=1, err=0.
//   2. Codes 0,1,3 -> err=1 the cycle after the 3, err_exp=2, err_dat=3, state=FAIL.
//      Then 0,1 -> no change.
//   3. Codes 0,1 with vld gaps of 3 cycles, then 2,3,4 -> done=1, pass_cnt=1.
//      HOLD_OK=1: 0,1,1,2 -> state=RUN, cnt=3.
//      HOLD_OK=0: 0,1,1 -> err_exp=2, err_dat=1.
//   4. WRAP=1: two full passes -> pass_cnt=2.
//      WRAP=0: a pass then code 0 -> err=1, err_exp=0, err_dat=0.
//      PW=2: five passes -> pass_cnt=3 (saturated).
//   5. rst_n low asynchronously mid-pass at code 2 -> outputs zero before the next edge.
//      clr and vld(dat=0) high in the same cycle -> state=IDLE, cnt=0.
//   6. DW=3, LAST=6 driven H..N (0..6) -> done=1, cnt=7.
//      First code 5 in IDLE -> err_exp=0, err_dat=5.

Source files
------------

// File: rtl/enum_sequence_checker.sv
// Receive-side monitor for an enumerated code stream: checks that valid codes step
// strictly through 0..LAST, counting completed passes and latching the first mismatch.
module enum_sequence_checker #(
    parameter int DW      = 3,
    parameter int LAST    = 4,
    parameter int HOLD_OK = 0,
    parameter int WRAP    = 1,
    parameter int PW      = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clr,
    input  logic                        vld,
    input  logic [DW-1:0]               dat,
    output logic [1:0]                  state,
    output logic [DW-1:0]               exp,
    output logic [$clog2(LAST+2)-1:0]   cnt,
    output logic                        done,
    output logic                        err,
    output logic [DW-1:0]               err_exp,
    output logic [DW-1:0]               err_dat,
    output logic [PW-1:0]               pass_cnt
);

    localparam int CW = $clog2(LAST + 2);

    localparam logic [DW-1:0] LAST_C   = DW'(LAST);
    localparam logic [CW-1:0] CNT_FULL = CW'(LAST + 1);
    localparam logic [PW-1:0] PASS_MAX = '1;

    generate
        if (LAST < 0 || LAST >= (1 << DW)) begin : g_bad_last
            $error("enum_sequence_checker: LAST=%0d does not fit in DW=%0d bits", LAST, DW);
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2,
        S_FAIL = 2'd3
    } state_e;

    state_e          state_q;
    logic [DW-1:0]   exp_q;
    logic [CW-1:0]   cnt_q;
    logic            done_q;
    logic            err_q;
    logic [DW-1:0]   err_exp_q;
    logic [DW-1:0]   err_dat_q;
    logic [PW-1:0]   pass_q;

    logic            is_zero;
    logic            hit;
    logic            hold_prev;
    logic            hold_last;
    logic            may_start;
    logic [PW-1:0]   pass_d;

    assign is_zero   = (dat == '0);
    assign hit       = (dat == exp_q);
    // In RUN exp_q is always >= 1, so exp_q-1 is the last accepted code.
    assign hold_prev = (HOLD_OK != 0) && (dat == exp_q - DW'(1));
    assign hold_last = (HOLD_OK != 0) && (dat == LAST_C);
    assign may_start = is_zero && ((state_q == S_IDLE) || (WRAP != 0));
    assign pass_d    = (pass_q == PASS_MAX) ? pass_q : pass_q + PW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            exp_q     <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            err_exp_q <= '0;
            err_dat_q <= '0;
            pass_q    <= '0;
        end else if (clr) begin
            state_q   <= S_IDLE;
            exp_q     <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            err_exp_q <= '0;
            err_dat_q <= '0;
            pass_q    <= '0;
        end else if (vld) begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (may_start) begin
                        // With LAST=0 the opening code is also the closing one.
                        if (LAST == 0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            exp_q   <= '0;
                            cnt_q   <= CNT_FULL;
                            pass_q  <= pass_d;
                        end else begin
                            state_q <= S_RUN;
                            done_q  <= 1'b0;
                            exp_q   <= DW'(1);
                            cnt_q   <= CW'(1);
                        end
                    end else if (!(state_q == S_DONE && hold_last)) begin
                        state_q   <= S_FAIL;
                        done_q    <= 1'b0;
                        err_q     <= 1'b1;
                        err_exp_q <= '0;
                        err_dat_q <= dat;
                    end
                end
                S_RUN: begin
                    if (hit) begin
                        if (exp_q == LAST_C) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            exp_q   <= '0;
                            cnt_q   <= CNT_FULL;
                            pass_q  <= pass_d;
                        end else begin
                            exp_q   <= exp_q + DW'(1);
                            cnt_q   <= cnt_q + CW'(1);
                        end
                    end else if (!hold_prev) begin
                        state_q   <= S_FAIL;
                        err_q     <= 1'b1;
                        err_exp_q <= exp_q;
                        err_dat_q <= dat;
                    end
                end
                default: begin
                    // FAIL is absorbing; the first error stays latched.
                end
            endcase
        end
    end

    assign state    = state_q;
    assign exp      = exp_q;
    assign cnt      = cnt_q;
    assign done     = done_q;
    assign err      = err_q;
    assign err_exp  = err_exp_q;
    assign err_dat  = err_dat_q;
    assign pass_cnt = pass_q;

endmodule

// File: tb/tb_enum_sequence_checker.sv
// Scoreboard bench: five differently-configured checkers share one code stream and are
// compared every cycle against a pass-position model of the sequence rules.
module tb_enum_sequence_checker;

    localparam int NI = 5;
    localparam int LAST_A [NI] = '{4, 4, 6, 0, 4};
    localparam int HOLD_A [NI] = '{0, 1, 0, 1, 1};
    localparam int WRAP_A [NI] = '{1, 0, 1, 1, 1};
    localparam int PW_A   [NI] = '{8, 2, 8, 2, 2};

    typedef struct packed {
        logic [1:0] st;
        logic [2:0] ex;
        logic [3:0] cn;
        logic       dn;
        logic       er;
        logic [2:0] ee;
        logic [2:0] ed;
        logic [7:0] pc;
    } obs_t;
    typedef obs_t [NI-1:0] snap_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0;
    logic       vld = 1'b0;
    logic [2:0] dat = 3'd0;
    obs_t       obs [NI];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        localparam int L   = LAST_A[gi];
        localparam int CWI = $clog2(L + 2);
        localparam int PWI = PW_A[gi];
        logic [1:0]     st;
        logic [2:0]     ex;
        logic [CWI-1:0] cn;
        logic           dn;
        logic           er;
        logic [2:0]     ee;
        logic [2:0]     ed;
        logic [PWI-1:0] pc;
        enum_sequence_checker #(
            .DW(3), .LAST(L), .HOLD_OK(HOLD_A[gi]), .WRAP(WRAP_A[gi]), .PW(PWI)
        ) u_dut (
            .clk(clk), .rst_n(rst_n), .clr(clr), .vld(vld), .dat(dat),
            .state(st), .exp(ex), .cnt(cn), .done(dn), .err(er),
            .err_exp(ee), .err_dat(ed), .pass_cnt(pc)
        );
        assign obs[gi] = {st, ex, 4'(cn), dn, er, ee, ed, 8'(pc)};
    end

    // Model: n = codes accepted in the current pass (LAST+1 means complete).
    int  n_m    [NI];
    int  pass_m [NI];
    bit  fail_m [NI];
    int  ee_m   [NI];
    int  ed_m   [NI];

    snap_t sb_q [$];
    string tag_q [$];
    string phase = "reset";
    int    total = 0;
    int    bad = 0;
    int    txn = 0;

    function automatic void m_reset(int i);
        n_m[i] = 0; pass_m[i] = 0; fail_m[i] = 0; ee_m[i] = 0; ed_m[i] = 0;
    endfunction

    function automatic void m_step(int i, bit v, int d, bit c);
        int L = LAST_A[i];
        bit full;
        int want;
        if (c) begin
            m_reset(i);
            return;
        end
        if (!v || fail_m[i]) return;
        full = (n_m[i] == L + 1);
        want = full ? 0 : n_m[i];
        if ((!full || WRAP_A[i] != 0) && d == want) begin
            n_m[i] = want + 1;
            if (n_m[i] == L + 1 && pass_m[i] < (1 << PW_A[i]) - 1) pass_m[i]++;
        end else if (!(HOLD_A[i] != 0 && n_m[i] > 0 && d == n_m[i] - 1)) begin
            fail_m[i] = 1;
            ee_m[i] = want;
            ed_m[i] = d;
        end
    endfunction

    function automatic obs_t model_obs(int i);
        obs_t o;
        int   L = LAST_A[i];
        bit   full = (n_m[i] == L + 1);
        o.st = fail_m[i] ? 2'd3 : (n_m[i] == 0) ? 2'd0 : full ? 2'd2 : 2'd1;
        o.ex = 3'(full ? 0 : n_m[i]);
        o.cn = 4'(n_m[i]);
        o.dn = (o.st == 2'd2);
        o.er = fail_m[i];
        o.ee = 3'(ee_m[i]);
        o.ed = 3'(ed_m[i]);
        o.pc = 8'(pass_m[i]);
        return o;
    endfunction

    task automatic push_expect();
        snap_t s;
        for (int i = 0; i < NI; i++) s[i] = model_obs(i);
        sb_q.push_back(s);
        tag_q.push_back(phase);
    endtask

    task automatic cyc(bit v, int d, bit c);
        vld = v; dat = 3'(d); clr = c;
        @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) m_step(i, v, d, c);
        push_expect();
    endtask

    task automatic seq(int from, int to);
        for (int k = from; k <= to; k++) cyc(1'b1, k, 1'b0);
    endtask

    task automatic chk(string nm, int got, int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, got, want);
        end
    endtask

    task automatic async_rst();
        vld = 1'b0; clr = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        for (int i = 0; i < NI; i++) m_reset(i);
        push_expect();
        #1;
        chk("arst_state", int'(obs[0].st), 0);
        chk("arst_cnt", int'(obs[0].cn), 0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: one expected snapshot per sampled edge, compared on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                snap_t e;
                string t;
                e = sb_q.pop_front();
                t = tag_q.pop_front();
                txn++;
                for (int i = 0; i < NI; i++) begin
                    total++;
                    if (obs[i] !== e[i]) begin
                        bad++;
                        $display("FAIL %s u%0d: got st=%0d exp=%0d cnt=%0d done=%0d err=%0d ee=%0d ed=%0d pass=%0d want st=%0d exp=%0d cnt=%0d done=%0d err=%0d ee=%0d ed=%0d pass=%0d",
                                 t, i, obs[i].st, obs[i].ex, obs[i].cn, obs[i].dn, obs[i].er,
                                 obs[i].ee, obs[i].ed, obs[i].pc, e[i].st, e[i].ex, e[i].cn,
                                 e[i].dn, e[i].er, e[i].ee, e[i].ed, e[i].pc);
                    end
                end
                $display("txn %0d [%s] vld=%0d dat=%0d clr=%0d u0 st=%0d cnt=%0d pass=%0d",
                         txn, t, vld, dat, clr, obs[0].st, obs[0].cn, obs[0].pc);
            end
        end
    end

    initial begin
        for (int i = 0; i < NI; i++) m_reset(i);
        #1;
        push_expect();
        #11;
        rst_n = 1'b1;

        phase = "t1_full_pass";
        seq(0, 4);
        chk("t1_cnt", int'(obs[0].cn), 5);
        chk("t1_done", int'(obs[0].dn), 1);
        chk("t1_pass", int'(obs[0].pc), 1);
        chk("t1_err", int'(obs[0].er), 0);

        phase = "t2_skip";
        cyc(1'b0, 0, 1'b1);
        seq(0, 1);
        cyc(1'b1, 3, 1'b0);
        chk("t2_err", int'(obs[0].er), 1);
        chk("t2_err_exp", int'(obs[0].ee), 2);
        chk("t2_err_dat", int'(obs[0].ed), 3);
        seq(0, 1);
        chk("t2_sticky_state", int'(obs[0].st), 3);

        phase = "t3_gaps";
        cyc(1'b0, 0, 1'b1);
        for (int k = 0; k <= 1; k++) begin
            cyc(1'b1, k, 1'b0);
            repeat (3) cyc(1'b0, $urandom_range(0, 7), 1'b0);
        end
        seq(2, 4);
        chk("t3_done", int'(obs[0].dn), 1);
        chk("t3_pass", int'(obs[0].pc), 1);

        phase = "t3_hold";
        cyc(1'b0, 0, 1'b1);
        seq(0, 1);
        cyc(1'b1, 1, 1'b0);
        cyc(1'b1, 2, 1'b0);
        chk("t3_hold_state", int'(obs[1].st), 1);
        chk("t3_hold_cnt", int'(obs[1].cn), 3);
        chk("t3_nohold_exp", int'(obs[0].ee), 2);
        chk("t3_nohold_dat", int'(obs[0].ed), 1);

        phase = "t4_passes";
        cyc(1'b0, 0, 1'b1);
        seq(0, 4);
        seq(0, 4);
        chk("t4_wrap_pass", int'(obs[0].pc), 2);
        chk("t4_nowrap_err", int'(obs[1].er), 1);
        chk("t4_nowrap_ee", int'(obs[1].ee), 0);
        chk("t4_nowrap_ed", int'(obs[1].ed), 0);
        seq(0, 4);
        seq(0, 4);
        seq(0, 4);
        chk("t4_sat_pass", int'(obs[4].pc), 3);

        phase = "t5_async";
        cyc(1'b0, 0, 1'b1);
        seq(0, 2);
        async_rst();
        phase = "t5_clr_vld";
        seq(0, 1);
        cyc(1'b1, 0, 1'b1);
        chk("t5_clr_state", int'(obs[0].st), 0);
        chk("t5_clr_cnt", int'(obs[0].cn), 0);

        phase = "t6_last6";
        seq(0, 6);
        chk("t6_done", int'(obs[2].dn), 1);
        chk("t6_cnt", int'(obs[2].cn), 7);
        cyc(1'b0, 0, 1'b1);
        cyc(1'b1, 5, 1'b0);
        chk("t6_ee", int'(obs[2].ee), 0);
        chk("t6_ed", int'(obs[2].ed), 5);

        phase = "random";
        cyc(1'b0, 0, 1'b1);
        for (int k = 0; k < 400; k++) begin
            int r;
            int want0;
            r = $urandom_range(0, 99);
            want0 = (n_m[0] == LAST_A[0] + 1) ? 0 : n_m[0];
            if (r < 1) async_rst();
            else if (r < 4) cyc(1'b0, 0, 1'b1);
            else if (r < 30) cyc(1'b0, $urandom_range(0, 7), 1'b0);
            else if (r < 85) cyc(1'b1, want0, 1'b0);
            else cyc(1'b1, $urandom_range(0, 7), 1'b0);
        end

        vld = 1'b0; clr = 1'b0;
        for (int k = 0; k < 10 && sb_q.size() > 0; k++) @(negedge clk);
        #1;
        total++;
        if (sb_q.size() > 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
